// File: rtl/cache_mem_arbiter_if.sv
// Avalon request/response types and the arbiter's bus bundle: per-master ports,
// the shared memory port and arbitration status.
package cache_mem_arbiter_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic        waitrequest;
    logic [31:0] readdata;
  } avalon_resp_t;
endpackage

interface cache_mem_arbiter_if #(parameter int NUM_MASTERS = 2);
  import cache_mem_arbiter_pkg::*;
  localparam int ID_W = $clog2(NUM_MASTERS);

  avalon_req_t  [NUM_MASTERS-1:0] m_avn_req;
  avalon_resp_t [NUM_MASTERS-1:0] m_avn_resp;
  avalon_req_t                    mem_avn_req;
  avalon_resp_t                   mem_avn_resp;
  logic [ID_W-1:0]                grant_id;
  logic                           busy;

  modport slave  (input  m_avn_req, mem_avn_resp,
                  output m_avn_resp, mem_avn_req, grant_id, busy);
  modport master (output m_avn_req, mem_avn_resp,
                  input  m_avn_resp, mem_avn_req, grant_id, busy);
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon memory port between NUM_MASTERS requesters;
// grant is held through waitrequest and read data is routed back to its owner.
module cache_mem_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input logic               clk,
  input logic               rst,
  cache_mem_arbiter_if.slave bus
);
  import cache_mem_arbiter_pkg::*;
  localparam int ID_W = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state;
  logic [ID_W-1:0]        last_grant, lock_id, rd_owner, grant;
  logic                   rd_vld, found, accept;
  logic [NUM_MASTERS-1:0] req;
  avalon_req_t            mem_req;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++)
      req[i] = bus.m_avn_req[i].read | bus.m_avn_req[i].write;
    grant = last_grant;
    found = 1'b0;
    if (state == LOCKED) begin
      grant = lock_id;
      found = req[lock_id];
    end else begin
      // Scan starts just past the last winner so every master gets a turn.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        if (!found && req[(int'(last_grant) + k) % NUM_MASTERS]) begin
          grant = ID_W'((int'(last_grant) + k) % NUM_MASTERS);
          found = 1'b1;
        end
      end
    end
    mem_req = bus.m_avn_req[grant];
    if (!found || !rst) begin
      mem_req.read  = 1'b0;
      mem_req.write = 1'b0;
    end
    accept = (mem_req.read | mem_req.write) & ~bus.mem_avn_resp.waitrequest;
  end

  assign bus.mem_avn_req = mem_req;
  assign bus.grant_id    = rst ? grant : '0;
  assign bus.busy        = rst && (state == LOCKED);

  // Waitrequest is the only output that sees mem waitrequest combinationally.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.m_avn_resp[i].waitrequest = 1'b1;
      bus.m_avn_resp[i].readdata    = '0;
      if (rst && found && grant == ID_W'(i))
        bus.m_avn_resp[i].waitrequest = bus.mem_avn_resp.waitrequest;
      if (rd_vld && rd_owner == ID_W'(i))
        bus.m_avn_resp[i].readdata = bus.mem_avn_resp.readdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_MASTERS - 1);
      lock_id    <= '0;
      rd_vld     <= 1'b0;
      rd_owner   <= '0;
    end else begin
      rd_vld <= accept & mem_req.read;
      if (accept & mem_req.read) rd_owner <= grant;
      case (state)
        IDLE: if (found) begin
          if (!bus.mem_avn_resp.waitrequest) last_grant <= grant;
          else begin
            lock_id <= grant;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          // A master abandoning its locked request releases the port without a transfer.
          if (!found) state <= IDLE;
          else if (!bus.mem_avn_resp.waitrequest) begin
            last_grant <= lock_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed-vector bench for cache_mem_arbiter with two masters.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.NUM_MASTERS(2)) bus ();
  cache_mem_arbiter #(.NUM_MASTERS(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic clear_all();
    bus.m_avn_req[0] = '0;
    bus.m_avn_req[1] = '0;
    bus.mem_avn_resp = '0;
  endtask

  task automatic rd(input int m, input logic [31:0] addr);
    bus.m_avn_req[m].read    = 1'b1;
    bus.m_avn_req[m].address = addr;
  endtask

  // move from a checking point (negedge) to the next input-drive point
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_all();
    rd(0, 32'h10);
    rd(1, 32'h20);
    bus.mem_avn_resp.readdata = 32'hA5A5A5A5;
    #3;
    n_cmp++;
    if (bus.mem_avn_req.read !== 1'b0 || bus.mem_avn_req.write !== 1'b0) begin
      n_err++; $display("FAIL reset_mem_rw got %b%b want 00", bus.mem_avn_req.read, bus.mem_avn_req.write);
    end
    n_cmp++;
    if (bus.m_avn_resp[0].waitrequest !== 1'b1 || bus.m_avn_resp[1].waitrequest !== 1'b1) begin
      n_err++; $display("FAIL reset_wait got %b%b want 11", bus.m_avn_resp[1].waitrequest, bus.m_avn_resp[0].waitrequest);
    end
    n_cmp++;
    if (bus.m_avn_resp[0].readdata !== 32'h0 || bus.m_avn_resp[1].readdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata got %h %h want 0 0", bus.m_avn_resp[0].readdata, bus.m_avn_resp[1].readdata);
    end
    n_cmp++;
    if (bus.grant_id !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_status got grant=%b busy=%b want 0 0", bus.grant_id, bus.busy);
    end
    clear_all();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_first_grant();
    rd(0, 32'h100);
    rd(1, 32'h200);
    @(negedge clk);
    n_cmp++;
    if (bus.grant_id !== 1'b0 || bus.m_avn_resp[1].waitrequest !== 1'b1 ||
        bus.m_avn_resp[0].waitrequest !== 1'b0 || bus.mem_avn_req.address !== 32'h100) begin
      n_err++; $display("FAIL first_c0 got grant=%b w1=%b w0=%b addr=%h want 0 1 0 100",
        bus.grant_id, bus.m_avn_resp[1].waitrequest, bus.m_avn_resp[0].waitrequest, bus.mem_avn_req.address);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.grant_id !== 1'b1 || bus.m_avn_resp[0].waitrequest !== 1'b1 || bus.mem_avn_req.address !== 32'h200) begin
      n_err++; $display("FAIL first_c1 got grant=%b w0=%b addr=%h want 1 1 200",
        bus.grant_id, bus.m_avn_resp[0].waitrequest, bus.mem_avn_req.address);
    end
    clear_all();
    next_cycle();
  endtask

  task automatic test_lock();
    logic [3:0] exp_busy;
    exp_busy = 4'b1110;  // cycle 0 is the IDLE grant cycle, cycles 1..3 are LOCKED
    rd(1, 32'h40);
    bus.mem_avn_resp.waitrequest = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) rd(0, 32'h80);
      if (c == 3) bus.mem_avn_resp.waitrequest = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.mem_avn_req.address !== 32'h40 || bus.grant_id !== 1'b1 || bus.mem_avn_req.read !== 1'b1 ||
          bus.busy !== exp_busy[c]) begin
        n_err++; $display("FAIL lock_c%0d got addr=%h grant=%b rd=%b busy=%b want 40 1 1 %b",
          c, bus.mem_avn_req.address, bus.grant_id, bus.mem_avn_req.read, bus.busy, exp_busy[c]);
      end
      next_cycle();
    end
    bus.m_avn_req[1] = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.grant_id !== 1'b0 || bus.mem_avn_req.address !== 32'h80 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL lock_c4 got grant=%b addr=%h busy=%b want 0 80 0",
        bus.grant_id, bus.mem_avn_req.address, bus.busy);
    end
    clear_all();
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_1010;  // bit c = expected grant in cycle c: 0,1,0,1,...
    rd(0, 32'h0);
    rd(1, 32'h4);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.grant_id !== exp_seq[c] || bus.mem_avn_req.read !== 1'b1) begin
        n_err++; $display("FAIL rr_c%0d got grant=%b rd=%b want %b 1", c, bus.grant_id, bus.mem_avn_req.read, exp_seq[c]);
      end
      next_cycle();
    end
    clear_all();
  endtask

  task automatic test_read_return();
    rd(0, 32'h100);
    @(negedge clk);
    n_cmp++;
    if (bus.grant_id !== 1'b0 || bus.mem_avn_req.address !== 32'h100) begin
      n_err++; $display("FAIL rret_issue got grant=%b addr=%h want 0 100", bus.grant_id, bus.mem_avn_req.address);
    end
    next_cycle();
    clear_all();
    bus.mem_avn_resp.readdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (bus.m_avn_resp[0].readdata !== 32'hDEADBEEF || bus.m_avn_resp[1].readdata !== 32'h0) begin
      n_err++; $display("FAIL rret_data got m0=%h m1=%h want deadbeef 0",
        bus.m_avn_resp[0].readdata, bus.m_avn_resp[1].readdata);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.m_avn_resp[0].readdata !== 32'h0) begin
      n_err++; $display("FAIL rret_idle got m0=%h want 0", bus.m_avn_resp[0].readdata);
    end
    clear_all();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    rd(1, 32'h300);
    next_cycle();
    clear_all();
    rd(0, 32'h400);
    bus.mem_avn_resp.readdata = 32'h1111_1111;
    @(negedge clk);
    n_cmp++;
    if (bus.m_avn_resp[1].readdata !== 32'h1111_1111 || bus.m_avn_resp[0].readdata !== 32'h0 || bus.grant_id !== 1'b0) begin
      n_err++; $display("FAIL b2b_c1 got m1=%h m0=%h grant=%b want 11111111 0 0",
        bus.m_avn_resp[1].readdata, bus.m_avn_resp[0].readdata, bus.grant_id);
    end
    next_cycle();
    clear_all();
    bus.mem_avn_resp.readdata = 32'h2222_2222;
    @(negedge clk);
    n_cmp++;
    if (bus.m_avn_resp[0].readdata !== 32'h2222_2222 || bus.m_avn_resp[1].readdata !== 32'h0) begin
      n_err++; $display("FAIL b2b_c2 got m0=%h m1=%h want 22222222 0",
        bus.m_avn_resp[0].readdata, bus.m_avn_resp[1].readdata);
    end
    clear_all();
    next_cycle();
  endtask

  task automatic test_write();
    bus.m_avn_req[1].write       = 1'b1;
    bus.m_avn_req[1].address     = 32'h80;
    bus.m_avn_req[1].writedata   = 32'h12345678;
    bus.m_avn_req[1].byte_enable = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_avn_req.write !== 1'b1 || bus.mem_avn_req.read !== 1'b0 || bus.mem_avn_req.address !== 32'h80 ||
        bus.mem_avn_req.writedata !== 32'h12345678 || bus.mem_avn_req.byte_enable !== 4'b0011 || bus.grant_id !== 1'b1) begin
      n_err++; $display("FAIL write_fwd got wr=%b rd=%b addr=%h wd=%h be=%b grant=%b want 1 0 80 12345678 0011 1",
        bus.mem_avn_req.write, bus.mem_avn_req.read, bus.mem_avn_req.address,
        bus.mem_avn_req.writedata, bus.mem_avn_req.byte_enable, bus.grant_id);
    end
    next_cycle();
    clear_all();
    bus.mem_avn_resp.readdata = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++;
    if (bus.m_avn_resp[0].readdata !== 32'h0 || bus.m_avn_resp[1].readdata !== 32'h0) begin
      n_err++; $display("FAIL write_noret got m0=%h m1=%h want 0 0", bus.m_avn_resp[0].readdata, bus.m_avn_resp[1].readdata);
    end
    clear_all();
    next_cycle();
  endtask

  task automatic test_drop();
    // last grant is 1 here, so M0 wins and locks
    rd(0, 32'h500);
    bus.mem_avn_resp.waitrequest = 1'b1;
    next_cycle();
    bus.m_avn_req[0] = '0;
    rd(1, 32'h600);
    @(negedge clk);
    n_cmp++;
    if (bus.mem_avn_req.read !== 1'b0 || bus.busy !== 1'b1 || bus.m_avn_resp[1].waitrequest !== 1'b1) begin
      n_err++; $display("FAIL drop_locked got rd=%b busy=%b w1=%b want 0 1 1",
        bus.mem_avn_req.read, bus.busy, bus.m_avn_resp[1].waitrequest);
    end
    next_cycle();
    bus.mem_avn_resp.waitrequest = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.grant_id !== 1'b1 || bus.mem_avn_req.address !== 32'h600) begin
      n_err++; $display("FAIL drop_release got busy=%b grant=%b addr=%h want 0 1 600",
        bus.busy, bus.grant_id, bus.mem_avn_req.address);
    end
    clear_all();
    next_cycle();
  endtask

  task automatic test_reset_locked();
    rd(1, 32'h700);
    bus.mem_avn_resp.waitrequest = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 1'b1) begin
      n_err++; $display("FAIL rstlk_pre got busy=%b grant=%b want 1 1", bus.busy, bus.grant_id);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_avn_req.read !== 1'b0 || bus.mem_avn_req.write !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rstlk_async got rd=%b wr=%b busy=%b want 0 0 0",
        bus.mem_avn_req.read, bus.mem_avn_req.write, bus.busy);
    end
    next_cycle();
    rst = 1'b1;
    rd(0, 32'h800);
    bus.mem_avn_resp.waitrequest = 1'b0;
    bus.mem_avn_resp.readdata    = 32'h5555AAAA;
    @(negedge clk);
    n_cmp++;
    if (bus.grant_id !== 1'b0 || bus.mem_avn_req.address !== 32'h800 ||
        bus.m_avn_resp[0].readdata !== 32'h0 || bus.m_avn_resp[1].readdata !== 32'h0) begin
      n_err++; $display("FAIL rstlk_post got grant=%b addr=%h m0=%h m1=%h want 0 800 0 0",
        bus.grant_id, bus.mem_avn_req.address, bus.m_avn_resp[0].readdata, bus.m_avn_resp[1].readdata);
    end
    clear_all();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_lock();
    test_round_robin();
    test_read_return();
    test_back_to_back();
    test_write();
    test_drop();
    test_reset_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
